// File: rtl/hazard_detection_unit.sv
// -----------------------------------------------------------------------------
// hazard_detection_unit
//
// Load-use hazard detector and stall controller for the ID stage of a 5-stage
// pipeline. When the instruction in EX is a load whose destination matches a
// source register of the instruction in ID, the PC and IF/ID register are
// frozen for LOAD_STALL_CYCLES cycles and the ID control bubble mux inserts
// zeros. A taken branch/jump flushes IF/ID and overrides any stall.
//
// Handshake note: there is no valid/ready pair here. pc_write/if_id_write act
// as "ready" for the front end: an instruction advances from IF to ID only on
// an edge where both are 1. Outputs are combinational from state and inputs.
//
// Ports:
//   clk            pipeline clock, rising edge
//   arst_n         asynchronous active-low reset
//   id_rs1/id_rs2  source register fields of the instruction in ID
//   id_uses_rs2    instruction in ID actually reads rs2
//   id_ex_mem_read instruction in EX is a load
//   id_ex_rd       destination register of the instruction in EX
//   branch_taken   taken branch/jump resolved this cycle (flush request)
//   pc_write       PC update enable
//   if_id_write    IF/ID register enable
//   if_id_flush    clear IF/ID to NOP
//   ctrl_select    bubble mux select: 1 = pass decoded controls, 0 = zeros
//   stall_count    saturating count of stalled cycles since reset
//   dbg_state      current FSM state (0 = IDLE, 1 = STALL)
// -----------------------------------------------------------------------------
module hazard_detection_unit #(
    parameter int REG_ADDR_W        = 5,
    parameter int LOAD_STALL_CYCLES = 1   // legal range 1..15
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_uses_rs2,
    input  logic                  id_ex_mem_read,
    input  logic [REG_ADDR_W-1:0] id_ex_rd,
    input  logic                  branch_taken,
    output logic                  pc_write,
    output logic                  if_id_write,
    output logic                  if_id_flush,
    output logic                  ctrl_select,
    output logic [15:0]           stall_count,
    output logic                  dbg_state
);

    typedef enum logic {
        IDLE  = 1'b0,
        STALL = 1'b1
    } state_t;

    // The first stall cycle is spent in IDLE (zero-latency detection), so the
    // STALL state only has to cover the remaining LOAD_STALL_CYCLES-1 cycles.
    localparam logic [3:0] STALL_RELOAD = 4'(LOAD_STALL_CYCLES - 1);

    state_t     state, state_nxt;
    logic [3:0] remaining, remaining_nxt;
    logic       hz;

    // x0 is hardwired to zero, so a load targeting it never creates a hazard.
    assign hz = id_ex_mem_read && (id_ex_rd != '0) &&
                ((id_ex_rd == id_rs1) || (id_uses_rs2 && (id_ex_rd == id_rs2)));

    // State register
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state     <= IDLE;
            remaining <= 4'd0;
        end else begin
            state     <= state_nxt;
            remaining <= remaining_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt     = state;
        remaining_nxt = remaining;
        if (branch_taken) begin
            state_nxt     = IDLE;
            remaining_nxt = 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (hz && (LOAD_STALL_CYCLES > 1)) begin
                        state_nxt     = STALL;
                        remaining_nxt = STALL_RELOAD;
                    end
                end
                STALL: begin
                    // ID/EX holds a bubble during STALL, so hz is not looked at.
                    remaining_nxt = remaining - 4'd1;
                    if (remaining == 4'd1) begin
                        state_nxt = IDLE;
                    end
                end
                default: begin
                    state_nxt     = IDLE;
                    remaining_nxt = 4'd0;
                end
            endcase
        end
    end

    // Output logic (Mealy). Reset gates the outputs directly so they read 0
    // for the whole time reset is held, not just after the next edge.
    always_comb begin
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        if_id_flush = 1'b0;
        ctrl_select = 1'b0;
        if (!arst_n) begin
            pc_write    = 1'b0;
        end else if (branch_taken) begin
            pc_write    = 1'b1;
            if_id_write = 1'b1;
            if_id_flush = 1'b1;
            ctrl_select = 1'b0;
        end else if ((state == STALL) || hz) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            ctrl_select = 1'b0;
        end else begin
            pc_write    = 1'b1;
            if_id_write = 1'b1;
            ctrl_select = 1'b1;
        end
    end

    // Stall cycle counter, saturating at all-ones
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            stall_count <= 16'd0;
        end else if (!pc_write && (stall_count != 16'hFFFF)) begin
            stall_count <= stall_count + 16'd1;
        end
    end

    assign dbg_state = (state == STALL);

endmodule
